rr_arbiter8_16: RTL and testbench

Round-robin arbiter that shares one 16-bit output channel between eight requesters. Each grant covers a whole packet: the channel stays locked to one requester until that requester transfers a word with `last` set. A Mux8Way16 selects the owner's data lane. Data goes out through a single registered valid/ready stage to the downstream consumer.

---
 rtl/rr_arbiter8_16_pkg.sv | 21 ++
 rtl/rr_arbiter8_16_if.sv | 32 +++
 rtl/rr_arbiter8_16_mux8way16.sv | 35 +++
 rtl/rr_arbiter8_16.sv | 123 ++++++++++++
 tb/tb_rr_arbiter8_16.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_arbiter8_16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_pkg
// Brief    : Shared constants and FSM state type for the 8-way, 16-bit
//            packet round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package arb_pkg;

    localparam int NREQ = 8;    // number of requesters
    localparam int DW   = 16;   // data lane width
    localparam int IDXW = 3;    // requester index width

    // IDLE: arbitrating between packets; LOCKED: channel owned until last word
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter8_16_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter8_16_if
// Brief    : Request-side and consumer-side handshake bundle of the arbiter.
//            master = traffic generator / consumer, slave = arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface rr_arbiter8_16_if;
    import arb_pkg::*;

    logic [NREQ-1:0]    in_valid;
    logic [NREQ*DW-1:0] in_data;
    logic [NREQ-1:0]    in_last;
    logic [NREQ-1:0]    in_ready;
    logic               out_valid;
    logic [DW-1:0]      out_data;
    logic               out_last;
    logic [IDXW-1:0]    out_src;
    logic               out_ready;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_src
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_src
    );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter8_16_mux8way16.sv
`default_nettype none
// ============================================================================
// Module   : Mux8Way16
// Brief    : Eight-input, 16-bit wide multiplexer; sel=0 picks a, 7 picks h.
// Revision : 1.0 - initial release
// ============================================================================
module Mux8Way16 (
    input  wire logic [15:0] a,
    input  wire logic [15:0] b,
    input  wire logic [15:0] c,
    input  wire logic [15:0] d,
    input  wire logic [15:0] e,
    input  wire logic [15:0] f,
    input  wire logic [15:0] g,
    input  wire logic [15:0] h,
    input  wire logic [2:0]  sel,
    output logic      [15:0] out
);

    // Pure selection, no state
    always_comb begin
        case (sel)
            3'd0:    out = a;
            3'd1:    out = b;
            3'd2:    out = c;
            3'd3:    out = d;
            3'd4:    out = e;
            3'd5:    out = f;
            3'd6:    out = g;
            default: out = h;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter8_16.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter8_16
// Brief    : Packet-granular round-robin arbiter, 8 requesters onto one
//            16-bit channel with a single registered valid/ready output stage.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter8_16
    import arb_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst_n,
    rr_arbiter8_16_if.slave  bus
);

    arb_state_t      r_state;
    logic [IDXW-1:0] r_owner;
    logic [IDXW-1:0] r_ptr;

    logic            r_out_valid;
    logic [DW-1:0]   r_out_data;
    logic            r_out_last;
    logic [IDXW-1:0] r_out_src;

    logic            w_can_load;
    logic            w_xfer;
    logic            w_owner_last;
    logic [DW-1:0]   w_mux_data;
    logic [NREQ-1:0] w_in_ready;

    // First requesting index at or after base, wrapping modulo 8
    function automatic logic [IDXW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                                input logic [IDXW-1:0] base);
        logic [IDXW-1:0] idx;
        logic [IDXW-1:0] pick;
        logic            found;
        pick  = base;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = base + k[IDXW-1:0];
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    Mux8Way16 u_mux (
        .a   (bus.in_data[0*DW +: DW]),
        .b   (bus.in_data[1*DW +: DW]),
        .c   (bus.in_data[2*DW +: DW]),
        .d   (bus.in_data[3*DW +: DW]),
        .e   (bus.in_data[4*DW +: DW]),
        .f   (bus.in_data[5*DW +: DW]),
        .g   (bus.in_data[6*DW +: DW]),
        .h   (bus.in_data[7*DW +: DW]),
        .sel (r_owner),
        .out (w_mux_data)
    );

    // Output slot is free if empty or being drained this cycle; in_valid never
    // enters in_ready so the handshake has no combinational loop
    assign w_can_load   = !r_out_valid || bus.out_ready;
    assign w_xfer       = (r_state == LOCKED) && w_can_load && bus.in_valid[r_owner];
    assign w_owner_last = bus.in_last[r_owner];

    // Ready only toward the current owner, and only while the output can take a word
    always_comb begin
        w_in_ready = '0;
        if ((r_state == LOCKED) && w_can_load)
            w_in_ready[r_owner] = 1'b1;
    end

    // Arbitration FSM: pick in IDLE, hold the lock until the owner's last word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|bus.in_valid) begin
                        r_owner <= rr_pick(bus.in_valid, r_ptr);
                        r_state <= LOCKED;
                    end
                end
                default: begin
                    if (w_xfer && w_owner_last) begin
                        r_ptr   <= r_owner + 3'd1;
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Output register: load on transfer, otherwise empty once drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_src   <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux_data;
            r_out_last  <= w_owner_last;
            r_out_src   <= r_owner;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.out_src   = r_out_src;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter8_16.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter8_16
// Brief    : Self-checking bench for rr_arbiter8_16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter8_16;
    import arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_arbiter8_16_if bus();

    rr_arbiter8_16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural reference: packet ownership plus a one-word output buffer
    bit          m_locked;
    int          m_owner;
    int          m_ptr;
    bit          m_ov;
    logic [15:0] m_od;
    bit          m_ol;
    int          m_os;

    int          src_log[$];
    logic [15:0] word_log[$];

    typedef struct {
        logic [7:0]  valid;
        logic [7:0]  last;
        int          lane;
        logic [15:0] word;
        logic [7:0]  e_rdy;
        logic        e_ov;
        logic [15:0] e_od;
        logic        e_ol;
        logic [2:0]  e_os;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_locked = 0; m_owner = 0; m_ptr = 0;
        m_ov = 0; m_od = '0; m_ol = 0; m_os = 0;
    endfunction

    function automatic logic [7:0] model_ready();
        if (m_locked && (!m_ov || bus.out_ready))
            return 8'(1 << m_owner);
        return 8'h00;
    endfunction

    function automatic void model_step();
        bit can_load;
        bit xfer;
        int pick;
        can_load = !m_ov || bus.out_ready;
        xfer     = m_locked && can_load && bus.in_valid[m_owner];
        if (xfer) begin
            m_od = bus.in_data[16*m_owner +: 16];
            m_ol = bus.in_last[m_owner];
            m_os = m_owner;
            m_ov = 1;
        end else if (m_ov && bus.out_ready) begin
            m_ov = 0;
        end
        if (!m_locked) begin
            pick = -1;
            for (int k = 0; k < 8; k++)
                if (pick < 0 && bus.in_valid[(m_ptr + k) % 8]) pick = (m_ptr + k) % 8;
            if (pick >= 0) begin
                m_owner  = pick;
                m_locked = 1;
            end
        end else if (xfer && bus.in_last[m_owner]) begin
            m_locked = 0;
            m_ptr    = (m_owner + 1) % 8;
        end
    endfunction

    function automatic logic [63:0] dut_vec();
        return 64'({bus.in_ready, bus.out_valid, bus.out_data, bus.out_last, bus.out_src});
    endfunction

    task automatic check_model(input string tag);
        check(tag, dut_vec(), 64'({model_ready(), m_ov, m_od, m_ol, 3'(m_os)}));
    endtask

    // Called just after a falling edge with inputs already applied
    task automatic tick(input string tag);
        #1;
        check_model(tag);
        if (bus.out_valid && bus.out_ready) begin
            src_log.push_back(int'(bus.out_src));
            word_log.push_back(bus.out_data);
        end
        model_step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.in_valid  = '0;
        bus.in_last   = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check(tag, dut_vec(), 64'd0);
        model_reset();
        src_log.delete();
        word_log.delete();
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic fill_lanes(input int lane, input logic [15:0] word);
        for (int i = 0; i < 8; i++) bus.in_data[16*i +: 16] = 16'hDE00 | 16'(i);
        bus.in_data[16*lane +: 16] = word;
    endtask

    task automatic check_log(input string tag, input int exp_src[$]);
        check({tag, "_count"}, 64'(src_log.size()), 64'(exp_src.size()));
        for (int k = 0; k < exp_src.size() && k < src_log.size(); k++)
            check({tag, "_src"}, 64'(src_log[k]), 64'(exp_src[k]));
    endtask

    initial begin
        int fired;
        int w;

        tbl[0] = '{8'h04, 8'h00, 2, 16'h1111, 8'h00, 1'b0, 16'h0000, 1'b0, 3'd0};
        tbl[1] = '{8'h04, 8'h00, 2, 16'h1111, 8'h04, 1'b0, 16'h0000, 1'b0, 3'd0};
        tbl[2] = '{8'h04, 8'h00, 2, 16'h2222, 8'h04, 1'b1, 16'h1111, 1'b0, 3'd2};
        tbl[3] = '{8'h04, 8'h04, 2, 16'h3333, 8'h04, 1'b1, 16'h2222, 1'b0, 3'd2};
        tbl[4] = '{8'h00, 8'h00, 2, 16'h0000, 8'h00, 1'b1, 16'h3333, 1'b1, 3'd2};
        tbl[5] = '{8'h0B, 8'hFF, 3, 16'h4444, 8'h00, 1'b0, 16'h3333, 1'b1, 3'd2};
        tbl[6] = '{8'h0B, 8'hFF, 3, 16'h4444, 8'h08, 1'b0, 16'h3333, 1'b1, 3'd2};
        tbl[7] = '{8'h00, 8'h00, 3, 16'h0000, 8'h00, 1'b1, 16'h4444, 1'b1, 3'd3};

        clear_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("reset_state", dut_vec(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester 3-word packet, then ptr=3 shows via pick of req 3 over 0/1
        for (int r = 0; r < 8; r++) begin
            bus.in_valid  = tbl[r].valid;
            bus.in_last   = tbl[r].last;
            bus.out_ready = 1'b1;
            fill_lanes(tbl[r].lane, tbl[r].word);
            #1;
            check($sformatf("table_row%0d", r), dut_vec(),
                  64'({tbl[r].e_rdy, tbl[r].e_ov, tbl[r].e_od, tbl[r].e_ol, tbl[r].e_os}));
            tick("table_model");
        end

        // Fairness: everyone always requesting 1-word packets
        do_reset("reset_fair");
        bus.in_valid = 8'hFF;
        bus.in_last  = 8'hFF;
        for (int i = 0; i < 8; i++) bus.in_data[16*i +: 16] = 16'(16'h1111 * i);
        for (int t = 0; t < 19; t++) tick("fair_model");
        check_log("fair", '{0, 1, 2, 3, 4, 5, 6, 7, 0});

        // Wrap-around: get ptr to 7, then 7 and 0 requesting, ptr ends at 1
        do_reset("reset_wrap");
        bus.in_last  = 8'hFF;
        bus.in_valid = 8'h40;
        repeat (2) tick("wrap_model");
        bus.in_valid = 8'h81;
        repeat (4) tick("wrap_model");
        bus.in_valid = 8'h03;
        repeat (2) tick("wrap_model");
        bus.in_valid = 8'h00;
        repeat (2) tick("wrap_model");
        check_log("wrap", '{6, 7, 0, 1});

        // Backpressure: 6-word packet from req 1, consumer stalls 4 cycles
        do_reset("reset_bp");
        w = 0;
        for (int t = 0; t < 16; t++) begin
            bus.in_valid[1] = (w < 6);
            bus.in_last[1]  = (w == 5);
            bus.in_data[16 +: 16] = 16'h0100 + 16'(w);
            bus.out_ready   = !(t >= 4 && t < 8);
            #1;
            fired = int'(bus.in_valid[1] && bus.in_ready[1]);
            tick("bp_model");
            w += fired;
        end
        check("bp_words", 64'(word_log.size()), 64'd6);
        for (int k = 0; k < 6 && k < word_log.size(); k++)
            check("bp_word", 64'(word_log[k]), 64'(16'h0100 + 16'(k)));

        // Owner stall: req 2 drops valid for 3 cycles while req 5 waits
        do_reset("reset_stall");
        bus.in_valid[5] = 1'b1;
        bus.in_last[5]  = 1'b1;
        bus.in_data[80 +: 16] = 16'h5555;
        w = 0;
        for (int t = 0; t < 12; t++) begin
            bus.in_valid[2] = (w < 4) && !(t >= 3 && t < 6);
            bus.in_last[2]  = (w == 3);
            bus.in_data[32 +: 16] = 16'h0200 + 16'(w);
            #1;
            fired = int'(bus.in_valid[2] && bus.in_ready[2]);
            tick("stall_model");
            w += fired;
        end
        check_log("stall", '{2, 2, 2, 2, 5});

        // Reset mid-packet: ptr must restart at 0 (stale ptr would pick 7)
        do_reset("reset_mid_a");
        bus.in_last  = 8'h40;
        bus.in_valid = 8'h40;
        repeat (2) tick("mid_model");
        bus.in_valid = 8'h08;
        bus.in_last  = 8'h00;
        bus.in_data[48 +: 16] = 16'h3A3A;
        repeat (3) tick("mid_model");
        do_reset("reset_mid_pkt");
        bus.in_valid = 8'h81;
        bus.in_last  = 8'hFF;
        repeat (3) tick("mid_model");
        check_log("mid_after", '{0});

        // Random traffic against the reference model
        do_reset("reset_rand");
        for (int t = 0; t < 600; t++) begin
            bus.in_valid  = 8'($urandom);
            bus.in_last   = 8'($urandom) & 8'($urandom);
            bus.in_data   = {$urandom, $urandom, $urandom, $urandom};
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick("rand_model");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
